// File: rtl/dllp_ack_proc_if.sv
// DLLP receive beats, transmitter sequence state and replay-buffer controls
// exchanged between the ACK/NAK processor and its neighbours.
interface dllp_ack_proc_if;
   logic        dllp_valid;
   logic        dllp_sop;
   logic [15:0] dllp_data;
   logic [11:0] next_tx_seq;
   logic        busy_n;
   logic [1:0]  ack_nack;
   logic [11:0] seq;
   logic        tim_out;
   logic [11:0] acked_seq;
   logic        dllp_err;
   logic [1:0]  err_code;
   logic        link_retrain;

   modport master (
      output dllp_valid, dllp_sop, dllp_data, next_tx_seq, busy_n,
      input  ack_nack, seq, tim_out, acked_seq, dllp_err, err_code, link_retrain
   );

   modport slave (
      input  dllp_valid, dllp_sop, dllp_data, next_tx_seq, busy_n,
      output ack_nack, seq, tim_out, acked_seq, dllp_err, err_code, link_retrain
   );
endinterface

// File: rtl/dllp_ack_proc.sv
// Receive-side ACK/NAK processor: frames 3-beat DLLPs, checks CRC-16 and
// sequence range, and owns the replay timer, REPLAY_NUM and AckD_SEQ.
//
// state | meaning
// IDLE  | waiting for beat 0 (valid & sop)
// B1    | beat 0 held, waiting for beat 1
// B2    | beat 1 held, beat 2 (CRC) is checked as it arrives
// CHK   | verdict of the previous DLLP is on the outputs; a new beat 0 is accepted
module dllp_ack_proc #(
   parameter int TIMER_LIMIT = 711
) (
   input logic            i_clk,
   input logic            i_reset,
   dllp_ack_proc_if.slave bus
);

   localparam int TW = $clog2(TIMER_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_B1, S_B2, S_CHK} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_beat0, r_beat1;
   logic [11:0] r_acked;
   logic [11:0] r_seq;
   logic [1:0]  r_ack_nack;
   logic        r_tim_out;
   logic        r_dllp_err;
   logic [1:0]  r_err_code;
   logic        r_link_retrain;
   logic [TW-1:0] r_timer;
   logic [1:0]  r_replay_num;

   logic        w_b0, w_b1, w_b2, w_frm_err;
   logic        w_crc_ok, w_crc_err, w_seq_err, w_fwd, w_nak;
   logic        w_in_rng, w_elig, w_tc, w_tmo, w_rn_inc;
   logic [7:0]  w_type;
   logic [11:0] w_s, w_d, w_out;

   // MSB-first CRC-16 (poly 100B, init FFFF), transmitted complemented
   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 31; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
         else              c = {c[14:0], 1'b0};
      end
      return ~c;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_b0        = bus.dllp_valid & bus.dllp_sop;
      w_b1        = 1'b0;
      w_b2        = 1'b0;
      w_frm_err   = 1'b0;
      case (r_state)
         S_IDLE: if (w_b0) w_state_nxt = S_B1;
         S_B1: begin
            if (w_b0) begin
               w_frm_err   = 1'b1;
               w_state_nxt = S_B1;
            end else if (bus.dllp_valid) begin
               w_b1        = 1'b1;
               w_state_nxt = S_B2;
            end
         end
         S_B2: begin
            if (w_b0) begin
               w_frm_err   = 1'b1;
               w_state_nxt = S_B1;
            end else if (bus.dllp_valid) begin
               w_b2        = 1'b1;
               w_state_nxt = S_CHK;
            end
         end
         S_CHK: w_state_nxt = w_b0 ? S_B1 : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_type    = r_beat0[15:8];
   assign w_s       = r_beat1[11:0];
   assign w_out     = bus.next_tx_seq - r_acked - 12'd1;
   assign w_d       = w_s - r_acked;
   assign w_in_rng  = (w_d <= w_out);
   assign w_crc_ok  = (crc16({r_beat0, r_beat1}) == bus.dllp_data);
   assign w_crc_err = w_b2 & ~w_crc_ok;
   assign w_fwd     = w_b2 & w_crc_ok & (w_type == 8'h00) & (w_d != 12'd0) & w_in_rng;
   assign w_nak     = w_b2 & w_crc_ok & (w_type == 8'h10) & w_in_rng;
   assign w_seq_err = w_b2 & w_crc_ok & ((w_type == 8'h00) | (w_type == 8'h10)) & ~w_in_rng;

   // An ACK/NAK committing in the timeout cycle wins over the timeout
   assign w_elig   = (w_out != 12'd0) & bus.busy_n;
   assign w_tc     = w_elig & (r_timer == TW'(TIMER_LIMIT - 1));
   assign w_tmo    = w_tc & ~w_fwd & ~w_nak;
   assign w_rn_inc = (w_nak & (w_d == 12'd0)) | w_tmo;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_beat0        <= '0;
         r_beat1        <= '0;
         r_acked        <= 12'hFFF;
         r_seq          <= '0;
         r_ack_nack     <= 2'b00;
         r_tim_out      <= 1'b0;
         r_dllp_err     <= 1'b0;
         r_err_code     <= 2'b00;
         r_link_retrain <= 1'b0;
         r_timer        <= '0;
         r_replay_num   <= 2'd0;
      end else begin
         if (w_b0) r_beat0 <= bus.dllp_data;
         if (w_b1) r_beat1 <= bus.dllp_data;

         r_ack_nack <= w_fwd ? 2'b01 : (w_nak ? 2'b10 : 2'b00);
         if (w_fwd | w_nak) r_seq <= w_s;
         if (w_fwd | (w_nak & (w_d != 12'd0))) r_acked <= w_s;

         r_dllp_err <= w_frm_err | w_crc_err | w_seq_err;
         r_err_code <= w_frm_err ? 2'b11 : (w_crc_err ? 2'b01 : (w_seq_err ? 2'b10 : 2'b00));
         r_tim_out  <= w_tmo;

         if (w_fwd | w_nak | ~w_elig | w_tc) r_timer <= '0;
         else                                r_timer <= r_timer + TW'(1);

         if (w_fwd)                            r_replay_num <= 2'd0;
         else if (w_nak & (w_d != 12'd0))      r_replay_num <= 2'd1;
         else if (w_rn_inc)                    r_replay_num <= r_replay_num + 2'd1;
         r_link_retrain <= w_rn_inc & (r_replay_num == 2'd3);
      end
   end

   assign bus.ack_nack     = r_ack_nack;
   assign bus.seq          = r_seq;
   assign bus.tim_out      = r_tim_out;
   assign bus.acked_seq    = r_acked;
   assign bus.dllp_err     = r_dllp_err;
   assign bus.err_code     = r_err_code;
   assign bus.link_retrain = r_link_retrain;

endmodule
